// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Bit position of each segment inside a 7-bit segment word.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int MAX_DIG = 8;

    // Marks zero digits from the MSB downward. Stops at the first nonzero digit
    // or the first digit with its decimal point set. Digit 0 is never marked.
    function automatic logic [MAX_DIG-1:0] lzb_mask(input logic [4*MAX_DIG-1:0] value,
                                                    input logic [MAX_DIG-1:0]   dp,
                                                    input int                   ndig);
        logic [MAX_DIG-1:0] mask;
        logic               stop;
        mask = '0;
        stop = 1'b0;
        for (int i = MAX_DIG - 1; i >= 1; i--) begin
            if (i < ndig && !stop) begin
                if (value[i*4 +: 4] != 4'd0 || dp[i]) begin
                    stop = 1'b1;
                end else begin
                    mask[i] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/encode_7seg.sv
// BCD-to-7-segment encoder, active-high segments, bit0 = a ... bit6 = g.
module encode_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of latches.
        seg_o = SEG_OFF;
        case (bcd_i)
            4'd0: seg_o = 7'b0111111;
            4'd1: seg_o = 7'b0000110;
            4'd2: seg_o = 7'b1011011;
            4'd3: seg_o = 7'b1001111;
            4'd4: seg_o = 7'b1100110;
            4'd5: seg_o = 7'b1101101;
            4'd6: seg_o = 7'b1111101;
            4'd7: seg_o = 7'b0000111;
            4'd8: seg_o = 7'b1111111;
            4'd9: seg_o = 7'b1101111;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display with
// dead-time blanking, double-buffered input and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 1000,
    parameter int BLANK = 8
)
(
    input  logic              CLK,
    input  logic              RST_X,
    input  logic [4*NDIG-1:0] DIN,
    input  logic [NDIG-1:0]   DP_IN,
    input  logic              DIN_VLD,
    output logic              DIN_RDY,
    input  logic              LZB,
    output logic [6:0]        SEG,
    output logic              SEG_DP,
    output logic [NDIG-1:0]   AN_X,
    output logic              FRAME
);

    localparam int CNT_W = $clog2(DIV);
    localparam int DIG_W = $clog2(NDIG);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NDIG - 1);
    localparam logic [NDIG-1:0]  AN_ONE    = NDIG'(1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [4*NDIG-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [NDIG-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic              pend_full_q, pend_full_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              seg_dp_q, seg_dp_d;
    logic              frame_q, frame_d;

    logic              last_slot, boundary, accept;
    logic [3:0]        nib;
    logic              nib_dp, nib_blank;
    logic [6:0]        enc_seg;
    logic [MAX_DIG-1:0] blank_mask;

    assign last_slot = (cnt_q == CNT_LAST);
    assign boundary  = last_slot && (dig_q == DIG_LAST);
    assign accept    = DIN_VLD && !pend_full_q;

    assign blank_mask = lzb_mask(32'(disp_q), 8'(disp_dp_q), NDIG);
    assign nib_blank  = LZB && blank_mask[3'(dig_q)];

    always_comb begin
        nib    = 4'd0;
        nib_dp = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_q == DIG_W'(i)) begin
                nib    = disp_q[i*4 +: 4];
                nib_dp = disp_dp_q[i];
            end
        end
    end

    encode_7seg u_encode (
        .bcd_i (nib),
        .seg_o (enc_seg)
    );

    always_comb begin
        cnt_d       = last_slot ? '0 : cnt_q + 1'b1;
        dig_d       = dig_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        an_d        = '1;
        seg_d       = SEG_OFF;
        seg_dp_d    = 1'b0;
        frame_d     = boundary;

        if (last_slot) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end

        // Pending is empty whenever an accept is possible, so a frame
        // transfer and an accept never compete for the same cycle.
        if (accept) begin
            pend_d      = DIN;
            pend_dp_d   = DP_IN;
            pend_full_d = 1'b1;
        end else if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end

        if (cnt_q >= CNT_BLANK) begin
            an_d     = ~(AN_ONE << dig_q);
            seg_d    = (nib > 4'd9 || nib_blank) ? SEG_OFF : enc_seg;
            seg_dp_d = nib_dp;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            // NOTE: the data buffers are reset too, so the display reads 0 and no stale value survives reset.
            cnt_q       <= '0;
            dig_q       <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            seg_dp_q    <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            seg_dp_q    <= seg_dp_d;
            frame_q     <= frame_d;
        end
    end

    assign DIN_RDY = !pend_full_q;
    assign AN_X    = an_q;
    assign SEG     = seg_q;
    assign SEG_DP  = seg_dp_q;
    assign FRAME   = frame_q;

endmodule
